uart_led_cmd_parser: RTL

Downstream consumer of the UART receive path. It pops bytes from the RX FIFO output handshake and parses fixed-length LED command frames into single-cycle LED colour write strobes. It also returns a one-byte ACK/NAK per frame through the UART transmit start/busy handshake. It sits between the UART block and the LED colour register file / LED driver.

---
 rtl/uart_led_cmd_parser.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_led_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_led_cmd_parser
//
// Pops bytes from the UART RX FIFO handshake and parses fixed six-byte LED
// command frames:  A5 | ADDR | R | G | B | CHK   with CHK = ADDR^R^G^B.
// A good frame produces a single-cycle LED write strobe and an ACK (0x06);
// a bad checksum or out-of-range address produces a NAK (0x15) and a frame
// error pulse. A stalled frame (inter-byte timeout) is dropped with a frame
// error pulse and no reply. All outputs are registered.
//
// Ports
//   i_Clock        system clock
//   i_Reset        synchronous, active-high reset
//   i_Rx_Data      received byte, valid while i_Data_Ready=1
//   i_Data_Ready   received byte available
//   o_Read_Data    one-cycle pulse consuming the current byte
//   o_Tx_Start     one-cycle pulse requesting transmission of o_Tx_Data
//   o_Tx_Data      ACK/NAK byte, held until the next frame completes
//   i_Busy_TX      transmitter busy
//   o_Wr           one-cycle LED write strobe
//   o_Wr_Addr      LED index (holds last written value)
//   o_Wr_Colour    {R,G,B} (holds last written value)
//   o_Frame_Error  one-cycle pulse on NAK or timeout
// -----------------------------------------------------------------------------
module uart_led_cmd_parser #(
  parameter int LED_COUNT      = 64,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [7:0]  i_Rx_Data,
  input  logic        i_Data_Ready,
  output logic        o_Read_Data,
  output logic        o_Tx_Start,
  output logic [7:0]  o_Tx_Data,
  input  logic        i_Busy_TX,
  output logic        o_Wr,
  output logic [7:0]  o_Wr_Addr,
  output logic [23:0] o_Wr_Colour,
  output logic        o_Frame_Error
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    LED_LIM  = 9'(LED_COUNT);
  localparam logic [7:0]    SYNC_B   = 8'hA5;
  localparam logic [7:0]    ACK_B    = 8'h06;
  localparam logic [7:0]    NAK_B    = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RED,
    S_GREEN,
    S_BLUE,
    S_CHECK,
    S_ACK
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    hold_q, hold_d;      // hold-off cycles remaining after a read
  logic          rd_q, rd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    red_q, red_d;
  logic [7:0]    green_q, green_d;
  logic [7:0]    blue_q, blue_d;
  logic          eval_q, eval_d;      // CHK byte taken, verdict issued next cycle
  logic          ok_q, ok_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          wr_q, wr_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [23:0]   wr_colour_q, wr_colour_d;
  logic          err_q, err_d;

  logic accept;
  logic in_frame;

  // The upstream ready flag drops late, so a read pulse is followed by a
  // hold-off window during which i_Data_Ready is ignored. No byte is taken
  // while an ACK/NAK is waiting for the transmitter.
  assign accept   = i_Data_Ready && !rd_q && (hold_q == 2'd0) && (state_q != S_ACK);
  assign in_frame = (state_q == S_ADDR) || (state_q == S_RED) || (state_q == S_GREEN) ||
                    (state_q == S_BLUE) || (state_q == S_CHECK);

  always_comb begin
    state_d     = state_q;
    hold_d      = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    rd_d        = 1'b0;
    tmo_d       = tmo_q;
    csum_d      = csum_q;
    addr_d      = addr_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    eval_d      = 1'b0;
    ok_d        = ok_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    wr_d        = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_colour_d = wr_colour_q;
    err_d       = 1'b0;

    if (accept) begin
      rd_d   = 1'b1;
      hold_d = 2'd2;
    end

    // Inter-byte timeout: an accepted byte always beats an expiring count.
    // The verdict cycle after the CHK byte is never timed out.
    if (in_frame) begin
      if (accept) begin
        tmo_d = '0;
      end else if (!eval_q && (tmo_q == TMO_LAST)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept && (i_Rx_Data == SYNC_B)) begin
          state_d = S_ADDR;
          csum_d  = 8'h00;
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d  = i_Rx_Data;
          csum_d  = csum_q ^ i_Rx_Data;
          state_d = S_RED;
        end
      end
      S_RED: begin
        if (accept) begin
          red_d   = i_Rx_Data;
          csum_d  = csum_q ^ i_Rx_Data;
          state_d = S_GREEN;
        end
      end
      S_GREEN: begin
        if (accept) begin
          green_d = i_Rx_Data;
          csum_d  = csum_q ^ i_Rx_Data;
          state_d = S_BLUE;
        end
      end
      S_BLUE: begin
        if (accept) begin
          blue_d  = i_Rx_Data;
          csum_d  = csum_q ^ i_Rx_Data;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (eval_q) begin
          state_d   = S_ACK;
          wr_d      = ok_q;
          err_d     = !ok_q;
          tx_data_d = ok_q ? ACK_B : NAK_B;
          if (ok_q) begin
            wr_addr_d   = addr_q;
            wr_colour_d = {red_q, green_q, blue_q};
          end
        end else if (accept) begin
          eval_d = 1'b1;
          ok_d   = (i_Rx_Data == csum_q) && ({1'b0, addr_q} < LED_LIM);
        end
      end
      S_ACK: begin
        if (!i_Busy_TX) begin
          tx_start_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      hold_q      <= 2'd0;
      rd_q        <= 1'b0;
      tmo_q       <= '0;
      csum_q      <= 8'h00;
      addr_q      <= 8'h00;
      red_q       <= 8'h00;
      green_q     <= 8'h00;
      blue_q      <= 8'h00;
      eval_q      <= 1'b0;
      ok_q        <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      wr_q        <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_colour_q <= 24'h000000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rd_q        <= rd_d;
      tmo_q       <= tmo_d;
      csum_q      <= csum_d;
      addr_q      <= addr_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      eval_q      <= eval_d;
      ok_q        <= ok_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      wr_q        <= wr_d;
      wr_addr_q   <= wr_addr_d;
      wr_colour_q <= wr_colour_d;
      err_q       <= err_d;
    end
  end

  assign o_Read_Data   = rd_q;
  assign o_Tx_Start    = tx_start_q;
  assign o_Tx_Data     = tx_data_q;
  assign o_Wr          = wr_q;
  assign o_Wr_Addr     = wr_addr_q;
  assign o_Wr_Colour   = wr_colour_q;
  assign o_Frame_Error = err_q;

endmodule
